alarm_table_scanner: RTL and testbench

- Avalon-MM read master sitting directly upstream of the alarm system's 1024x32 on-chip RAM (s1 port).
- Software writes alarm entries into the RAM. On every minute tick this block walks a contiguous table of entries and compares each enabled entry with the current time.
- On each match it emits a one-cycle hit pulse with the entry index, which the alarm sequencer/buzzer logic consumes.

---
 rtl/alarm_table_scanner.sv | 124 ++++++++++++
 tb/tb_alarm_table_scanner.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_table_scanner.sv
// Alarm table scanner: on each minute tick, reads NUM_ENTRIES words from the alarm RAM
// and pulses alarm_hit with the entry index for every enabled entry that matches the time.
module alarm_table_scanner #(
  parameter int                ADDR_W      = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 10'h3F0,
  parameter int                NUM_ENTRIES = 16,
  parameter int                IDX_W       = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [2:0]        cur_day,
  input  logic [4:0]        cur_hour,
  input  logic [5:0]        cur_min,
  output logic [ADDR_W-1:0] address,
  output logic              chipselect,
  output logic              write,
  output logic [3:0]        byteenable,
  input  logic [31:0]       readdata,
  output logic              alarm_hit,
  output logic [IDX_W-1:0]  hit_index,
  output logic              busy,
  output logic              tick_overrun,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CMP   = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [2:0]       day_l;
  logic [4:0]       hour_l;
  logic [5:0]       min_l;
  logic             pending;
  logic [7:0]       day_mask;
  logic             time_ok;
  logic             entry_hit;

  // Bus handshake: a read is requested only while chipselect is high (one cycle, in ISSUE);
  // the RAM has no wait states, so readdata belongs to that request in the following cycle.
  assign write      = 1'b0;
  assign byteenable = 4'hF;
  assign state_dbg  = state;

  assign idx_nxt = idx + 1'b1;

  // Day 7 lands on the padded zero bit, so it can never match.
  assign day_mask  = {1'b0, readdata[30:24]};
  assign time_ok   = (hour_l <= 5'd23) && (min_l <= 6'd59);
  assign entry_hit = readdata[31] && day_mask[day_l] && time_ok &&
                     (readdata[20:16] == hour_l) && (readdata[13:8] == min_l);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      day_l        <= '0;
      hour_l       <= '0;
      min_l        <= '0;
      pending      <= 1'b0;
      address      <= '0;
      chipselect   <= 1'b0;
      alarm_hit    <= 1'b0;
      hit_index    <= '0;
      busy         <= 1'b0;
      tick_overrun <= 1'b0;
    end else begin
      alarm_hit <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tick || pending) begin
            day_l      <= cur_day;
            hour_l     <= cur_hour;
            min_l      <= cur_min;
            idx        <= '0;
            pending    <= 1'b0;
            address    <= BASE_ADDR;
            chipselect <= 1'b1;
            busy       <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          chipselect <= 1'b0;
          state      <= S_CMP;
        end
        S_CMP: begin
          if (entry_hit) begin
            alarm_hit <= 1'b1;
            hit_index <= idx;
          end
          if (idx == LAST_IDX) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            idx        <= idx_nxt;
            address    <= BASE_ADDR + ADDR_W'(idx_nxt);
            chipselect <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        default: begin
          chipselect <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase

      // Only one tick may wait behind a running scan; further ones are dropped and flagged.
      if (tick && (state != S_IDLE)) begin
        if (!pending) pending <= 1'b1;
        else          tick_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alarm_table_scanner.sv
// Bench for alarm_table_scanner: RAM model, randomized tables and times, scoreboard of
// expected (cycle, index) hits, plus a single-entry instance for the smallest table.
module tb_alarm_table_scanner;

  localparam int                ADDR_W = 10;
  localparam logic [ADDR_W-1:0] BASE   = 10'h3F0;
  localparam int                N      = 16;
  localparam int                IDX_W  = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              tick = 1'b0;
  logic              tick2 = 1'b0;
  logic [2:0]        cur_day = '0;
  logic [4:0]        cur_hour = '0;
  logic [5:0]        cur_min = '0;

  logic [ADDR_W-1:0] address, address2;
  logic              chipselect, chipselect2;
  logic              write, write2;
  logic [3:0]        byteenable, byteenable2;
  logic [31:0]       readdata, readdata2;
  logic              alarm_hit, alarm_hit2;
  logic [IDX_W-1:0]  hit_index;
  logic [0:0]        hit_index2;
  logic              busy, busy2;
  logic              tick_overrun, tick_overrun2;
  logic [1:0]        state_dbg, state_dbg2;

  logic [31:0]       mem [0:1023];
  logic [ADDR_W-1:0] ram_a = '0;
  logic [ADDR_W-1:0] ram_a2 = '0;
  int                cyc = 0;
  int                n_checks = 0;
  int                n_fail = 0;
  int                cs2_count = 0;

  logic [37:0]       exp_q[$];
  logic [ADDR_W-1:0] addr_log[$];
  logic [37:0]       mon_e;

  alarm_table_scanner #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .NUM_ENTRIES(N), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .tick(tick), .cur_day(cur_day), .cur_hour(cur_hour),
    .cur_min(cur_min), .address(address), .chipselect(chipselect), .write(write),
    .byteenable(byteenable), .readdata(readdata), .alarm_hit(alarm_hit),
    .hit_index(hit_index), .busy(busy), .tick_overrun(tick_overrun), .state_dbg(state_dbg)
  );

  alarm_table_scanner #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .NUM_ENTRIES(1), .IDX_W(1)) dut1 (
    .clk(clk), .reset(reset), .tick(tick2), .cur_day(cur_day), .cur_hour(cur_hour),
    .cur_min(cur_min), .address(address2), .chipselect(chipselect2), .write(write2),
    .byteenable(byteenable2), .readdata(readdata2), .alarm_hit(alarm_hit2),
    .hit_index(hit_index2), .busy(busy2), .tick_overrun(tick_overrun2), .state_dbg(state_dbg2)
  );

  // ---------------- clock / RAM model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_a  <= address;
    ram_a2 <= address2;
    cyc    <= cyc + 1;
  end

  assign readdata  = mem[ram_a];
  assign readdata2 = mem[ram_a2];

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit entry_match(input logic [31:0] e, input int d, input int h, input int m);
    if (!e[31]) return 1'b0;
    if (d > 6 || h > 23 || m > 59) return 1'b0;
    return e[24 + d] && (int'(e[20:16]) == h) && (int'(e[13:8]) == m);
  endfunction

  function automatic logic [31:0] mk(input bit en, input logic [6:0] mask, input int h, input int m);
    return {en, mask, 3'($urandom), 5'(h), 2'($urandom), 6'(m), 8'($urandom)};
  endfunction

  // Expected hits for a scan whose tick was driven while cyc == t0.
  task automatic push_scan(input int t0, input int d, input int h, input int m);
    for (int i = 0; i < N; i++)
      if (entry_match(mem[BASE + i], d, h, m))
        exp_q.push_back({32'(t0 + 2 * i + 3), 6'(i)});
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    check("write_const", {63'b0, write}, 64'd0);
    check("byteenable_const", {60'b0, byteenable}, 64'hF);
    if (chipselect === 1'b1) addr_log.push_back(address);
    if (chipselect2 === 1'b1) cs2_count++;
    if (alarm_hit === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_hit: index %0d at cycle %0d, no hit expected", hit_index, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("hit_index", 64'(hit_index), 64'(mon_e[5:0]));
        check("hit_cycle", 64'(cyc), 64'(mon_e[37:6]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_time(input int d, input int h, input int m);
    cur_day  = 3'(d);
    cur_hour = 5'(h);
    cur_min  = 6'(m);
  endtask

  task automatic pulse_tick(output int t0);
    t0   = cyc;
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic clear_table();
    for (int i = 0; i < N; i++) mem[BASE + i] = mk(1'b0, 7'h00, 0, 0);
  endtask

  task automatic scan_and_check(input int d, input int h, input int m);
    int t0;
    set_time(d, h, m);
    addr_log.delete();
    pulse_tick(t0);
    push_scan(t0, d, h, m);
    check("busy_start", {63'b0, busy}, 64'd1);
    wait_cyc(t0 + 2 * N);
    check("busy_last", {63'b0, busy}, 64'd1);
    wait_cyc(t0 + 2 * N + 1);
    check("busy_end", {63'b0, busy}, 64'd0);
    wait_cyc(t0 + 2 * N + 2);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("trace_len", 64'(addr_log.size()), 64'(N));
    for (int i = 0; i < N && i < addr_log.size(); i++)
      check("trace_addr", 64'(addr_log[i]), 64'(BASE + i));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    int d, h, m;
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    #2 reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_address", 64'(address), 64'd0);
    check("rst_chipselect", {63'b0, chipselect}, 64'd0);
    check("rst_alarm_hit", {63'b0, alarm_hit}, 64'd0);
    check("rst_hit_index", 64'(hit_index), 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_overrun", {63'b0, tick_overrun}, 64'd0);
    reset = 1'b0;
    wait_cyc(cyc + 2);

    // Single match at index 3 (ignored low byte set).
    clear_table();
    mem[BASE + 3] = 32'h8208_0705;
    scan_and_check(1, 8, 7);

    // Disabled entry and day-mask mismatch.
    clear_table();
    mem[BASE + 0] = 32'h0108_0700;
    mem[BASE + 1] = 32'h8408_0700;
    scan_and_check(1, 8, 7);

    // Three matches at 23:59.
    clear_table();
    mem[BASE + 0]  = mk(1'b1, 7'h10, 23, 59);
    mem[BASE + 5]  = mk(1'b1, 7'h7F, 23, 59);
    mem[BASE + 15] = mk(1'b1, 7'h30, 23, 59);
    scan_and_check(4, 23, 59);

    // Snapshot, pending restart and overrun.
    clear_table();
    mem[BASE + 2] = mk(1'b1, 7'h08, 8, 7);
    mem[BASE + 6] = mk(1'b1, 7'h08, 8, 8);
    set_time(3, 8, 7);
    pulse_tick(t0);
    push_scan(t0, 3, 8, 7);
    push_scan(t0 + 2 * N + 1, 3, 8, 8);
    wait_cyc(t0 + 5);
    cur_min = 6'd8;
    wait_cyc(t0 + 9);
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    wait_cyc(t0 + 12);
    check("overrun_after_one_pending", {63'b0, tick_overrun}, 64'd0);
    wait_cyc(t0 + 13);
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    wait_cyc(t0 + 15);
    check("overrun_set", {63'b0, tick_overrun}, 64'd1);
    wait_cyc(t0 + 2 * N + 1);
    check("pending_gap_busy", {63'b0, busy}, 64'd0);
    wait_cyc(t0 + 2 * N + 2);
    check("pending_restart_busy", {63'b0, busy}, 64'd1);
    wait_cyc(t0 + 4 * N + 2);
    check("second_scan_end", {63'b0, busy}, 64'd0);
    wait_cyc(t0 + 4 * N + 6);
    check("no_third_scan", {63'b0, busy}, 64'd0);
    check("overrun_sticky", {63'b0, tick_overrun}, 64'd1);
    check("pending_drained", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a scan that would hit at index 10.
    clear_table();
    mem[BASE + 10] = mk(1'b1, 7'h20, 12, 30);
    set_time(5, 12, 30);
    pulse_tick(t0);
    wait_cyc(t0 + 9);
    check("pre_reset_chipselect", {63'b0, chipselect}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("async_chipselect", {63'b0, chipselect}, 64'd0);
    check("async_busy", {63'b0, busy}, 64'd0);
    check("async_alarm_hit", {63'b0, alarm_hit}, 64'd0);
    check("async_overrun", {63'b0, tick_overrun}, 64'd0);
    check("async_address", 64'(address), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_cyc(cyc + 40);
    check("post_reset_idle", {63'b0, busy}, 64'd0);
    scan_and_check(5, 12, 30);

    // Out-of-range times never match.
    clear_table();
    mem[BASE + 1] = mk(1'b1, 7'h7F, 24, 0);
    mem[BASE + 4] = mk(1'b1, 7'h7F, 10, 60);
    scan_and_check(2, 24, 0);
    scan_and_check(2, 10, 60);
    scan_and_check(7, 10, 0);

    // Randomized tables with planted matches.
    for (int s = 0; s < 8; s++) begin
      d = $urandom_range(0, 6);
      h = $urandom_range(0, 23);
      m = $urandom_range(0, 59);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) == 0)
          mem[BASE + i] = mk(1'($urandom_range(0, 3) != 0), 7'($urandom) | 7'(1 << d), h, m);
        else
          mem[BASE + i] = $urandom();
      end
      scan_and_check(d, h, m);
    end

    // Single-entry table.
    mem[BASE] = mk(1'b1, 7'h01, 6, 45);
    set_time(0, 6, 45);
    cs2_count = 0;
    t0 = cyc;
    tick2 = 1'b1;
    @(posedge clk);
    #1;
    tick2 = 1'b0;
    check("n1_busy_issue", {63'b0, busy2}, 64'd1);
    check("n1_cs_issue", {63'b0, chipselect2}, 64'd1);
    check("n1_address", 64'(address2), 64'(BASE));
    wait_cyc(t0 + 2);
    check("n1_busy_cmp", {63'b0, busy2}, 64'd1);
    check("n1_cs_cmp", {63'b0, chipselect2}, 64'd0);
    wait_cyc(t0 + 3);
    check("n1_busy_end", {63'b0, busy2}, 64'd0);
    check("n1_hit", {63'b0, alarm_hit2}, 64'd1);
    check("n1_hit_index", 64'(hit_index2), 64'd0);
    wait_cyc(t0 + 6);
    check("n1_cs_count", 64'(cs2_count), 64'd1);
    check("n1_hit_gone", {63'b0, alarm_hit2}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
